dcache_write_buffer: RTL and testbench

Posted-write buffer placed between the data cache's memory port and slow_memD, on the data path from the pipeline's data cache to slow memory.
- Absorbs dirty-block write-backs from the cache in 1 cycle and drains them to slow memory in the background.
- Forwards buffered data to cache refill reads that hit in the buffer.
- Passes refill reads that miss in the buffer through to memory.
- Upstream port uses the same protocol as slow memory, so the cache is unchanged.

---
 rtl/cache_pkg.sv | 17 +
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/dcache_write_buffer.sv | 167 ++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache write buffer: default widths,
// memory-side FSM encoding and block typedefs.
package cache_pkg;

  localparam int AW_DEF = 28;
  localparam int DW_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_READ  = 2'd2
  } mem_state_t;

  typedef logic [AW_DEF-1:0] blk_addr_t;
  typedef logic [DW_DEF-1:0] blk_data_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular store of posted write blocks with head/tail/count bookkeeping and
// a parallel address CAM that reports the newest valid matching entry.
module wb_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic                     push,
  input  logic                     coalesce,
  input  logic [$clog2(DEPTH)-1:0] coalesce_idx,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  input  logic [AW-1:0]            lookup_addr,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH)-1:0] head_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic [DW-1:0]            hit_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [IW-1:0]    head_reg;
  logic [IW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] match;

  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + IW'(1);
      if (pop)  head_reg <= head_reg + IW'(1);
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= wr_addr;
      data_mem[tail_reg] <= wr_data;
    end else if (coalesce) begin
      data_mem[coalesce_idx] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cam
      logic [IW-1:0] age;
      assign age       = IW'(gi) - head_reg;
      assign match[gi] = ({1'b0, age} < count_reg) && (addr_mem[gi] == lookup_addr);
    end
  endgenerate

  // Walk from oldest to newest so the last hit found is the newest one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head_reg + IW'(k)]) begin
        hit     = 1'b1;
        hit_idx = head_reg + IW'(k);
      end
    end
  end

  assign head_addr = addr_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign head_idx  = head_reg;
  assign count     = count_reg;
  assign hit_data  = data_mem[hit_idx];

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the data cache and slow memory: absorbs
// write-backs, forwards buffered blocks to refills, drains in background.
module dcache_write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          wb_empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  mem_state_t state_reg, state_next;

  logic          c_ready_reg, c_ready_next;
  logic [DW-1:0] c_rdata_reg, c_rdata_next;
  logic          mem_read_reg, mem_read_next;
  logic          mem_write_reg, mem_write_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic          wb_empty_reg, wb_empty_next;

  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data, hit_data;
  logic [IW-1:0] head_idx, hit_idx;
  logic [CW-1:0] count, count_next;
  logic          hit;

  logic read_req, read_hit, read_miss, write_req;
  logic drain_start, head_busy, coalesce, push, pop;

  // Requests are only taken when c_ready is low; the pulse cycle belongs to the cache.
  always_comb begin
    read_req    = c_read && !c_ready_reg && (state_reg != ST_READ);
    read_hit    = read_req && hit;
    read_miss   = read_req && !hit;
    drain_start = (state_reg == ST_IDLE) && !read_miss && (count != '0);
    // A head whose drain launches this edge is treated as in flight, so its
    // latched mem_wdata can never go stale through a coalesce.
    head_busy   = (state_reg == ST_DRAIN) || drain_start;
    write_req   = c_write && !c_read && !c_ready_reg;
    coalesce    = write_req && hit && !(head_busy && (hit_idx == head_idx));
    push        = write_req && !coalesce && (count < CW'(DEPTH));
    pop         = (state_reg == ST_DRAIN) && mem_ready;
  end

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .push         (push),
    .coalesce     (coalesce),
    .coalesce_idx (hit_idx),
    .wr_addr      (c_addr),
    .wr_data      (c_wdata),
    .pop          (pop),
    .lookup_addr  (c_addr),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .head_idx     (head_idx),
    .count        (count),
    .count_next   (count_next),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .hit_data     (hit_data)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (read_miss)        state_next = ST_READ;
        else if (drain_start) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (mem_ready) state_next = ST_IDLE;
      ST_READ:  if (mem_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    c_ready_next   = 1'b0;
    c_rdata_next   = c_rdata_reg;
    mem_read_next  = mem_read_reg;
    mem_write_next = mem_write_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (read_miss) begin
          mem_read_next = 1'b1;
          mem_addr_next = c_addr;
        end else if (drain_start) begin
          mem_write_next = 1'b1;
          mem_addr_next  = head_addr;
          mem_wdata_next = head_data;
        end
      end
      ST_DRAIN: if (mem_ready) mem_write_next = 1'b0;
      ST_READ: begin
        if (mem_ready) begin
          mem_read_next = 1'b0;
          c_ready_next  = 1'b1;
          c_rdata_next  = mem_rdata;
        end
      end
      default: ;
    endcase
    if (read_hit) begin
      c_ready_next = 1'b1;
      c_rdata_next = hit_data;
    end
    if (coalesce || push) c_ready_next = 1'b1;
  end

  assign wb_empty_next = (count_next == '0) && (state_next != ST_DRAIN);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      c_ready_reg   <= 1'b0;
      c_rdata_reg   <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      wb_empty_reg  <= 1'b1;
    end else begin
      c_ready_reg   <= c_ready_next;
      c_rdata_reg   <= c_rdata_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      wb_empty_reg  <= wb_empty_next;
    end
  end

  assign c_ready   = c_ready_reg;
  assign c_rdata   = c_rdata_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign wb_empty  = wb_empty_reg;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: acts as both the cache and a slow memory with
// programmable latency, checking against a latest-value-per-address model.
module tb_dcache_write_buffer;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset = 1'b1;
  logic          c_read = 1'b0, c_write = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          wb_empty;

  always #5 clk = ~clk;

  dcache_write_buffer dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .c_read     (c_read),
    .c_write    (c_write),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_rdata    (c_rdata),
    .c_ready    (c_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .wb_empty   (wb_empty)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slow memory contents, and the architectural view: latest value written per address.
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic [DW-1:0] wmodel    [logic [AW-1:0]];

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            rcyc;
  } txn_t;
  txn_t txn_log[$];

  int mem_lat  = 2;
  int wait_cnt = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  function automatic logic [DW-1:0] model_val(input logic [AW-1:0] a);
    return wmodel.exists(a) ? wmodel[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory responder: waits mem_lat cycles then gives a one-cycle mem_ready.
  initial begin
    txn_t t;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (wait_cnt >= mem_lat) begin
          t.is_wr = mem_write;
          t.addr  = mem_addr;
          t.rcyc  = cyc;
          if (mem_write) begin
            mem_store[mem_addr] = mem_wdata;
            t.data = mem_wdata;
          end else begin
            mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_val(mem_addr);
            t.data = mem_rdata;
          end
          txn_log.push_back(t);
          mem_ready = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  logic c_ready_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ((mem_read && mem_write) !== 1'b0) begin
        n_bad++;
        $display("FAIL mem_rd_wr_excl cyc=%0d got mem_read=%b mem_write=%b exp not both 1", cyc, mem_read, mem_write);
      end
      n_cmp++;
      if ((c_ready && c_ready_prev) !== 1'b0) begin
        n_bad++;
        $display("FAIL c_ready_double cyc=%0d got two consecutive c_ready exp single pulse", cyc);
      end
    end
    c_ready_prev = c_ready;
  end

  task automatic do_reset();
    c_read  = 1'b0;
    c_write = 1'b0;
    @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    wmodel  = mem_store;
    txn_log.delete();
    mon_en  = 1'b1;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rdata,
                        output int lat, output int ack_cyc);
    c_read  = rd;
    c_write = wr;
    c_addr  = a;
    c_wdata = d;
    lat     = 0;
    ack_cyc = -1;
    rdata   = '0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (c_ready === 1'b1) begin
        lat     = n;
        ack_cyc = cyc;
        rdata   = c_rdata;
        break;
      end
    end
    c_read  = 1'b0;
    c_write = 1'b0;
    n_cmp++;
    if (lat == 0) begin
      n_bad++;
      $display("FAIL req_timeout rd=%0b wr=%0b addr=%h got no c_ready exp c_ready within 400 cycles", rd, wr, a);
    end else begin
      if (wr && !rd) wmodel[a] = d;
      $display("txn rd=%0b wr=%0b addr=%h lat=%0d rdata=%h", rd, wr, a, lat, rdata);
    end
    @(negedge clk);
  endtask

  task automatic wait_empty(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (wb_empty === 1'b1 && mem_write === 1'b0 && mem_read === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (c_ready !== 1'b0) begin n_bad++; $display("FAIL reset_c_ready got=%b exp=0", c_ready); end
    n_cmp++; if (c_rdata !== '0) begin n_bad++; $display("FAIL reset_c_rdata got=%h exp=0", c_rdata); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (wb_empty !== 1'b1) begin n_bad++; $display("FAIL reset_wb_empty got=%b exp=1", wb_empty); end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d, rd;
    int lat, ack;
    bit ok;
    do_reset();
    mem_lat = 2;
    d = {16{8'hA5}};
    do_req(1'b0, 1'b1, 28'h0000010, d, rd, lat, ack);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL single_wr_lat got=%0d exp=1", lat); end
    n_cmp++;
    if (mem_write !== 1'b1 || mem_addr !== 28'h0000010 || mem_wdata !== d) begin
      n_bad++;
      $display("FAIL single_wr_drain got we=%b addr=%h data=%h exp we=1 addr=0000010 data=%h", mem_write, mem_addr, mem_wdata, d);
    end
    wait_empty(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_wr_empty got wb_empty=%b exp=1", wb_empty); end
    n_cmp++;
    if (txn_log.size() != 1 || !txn_log[0].is_wr || txn_log[0].addr !== 28'h0000010 || txn_log[0].data !== d) begin
      n_bad++;
      $display("FAIL single_wr_mem got ntxn=%0d exp one write of addr 0000010", txn_log.size());
    end
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] dv [1:5];
    int latv [1:5];
    int ackv [1:5];
    logic [DW-1:0] rd;
    bit ok;
    do_reset();
    mem_lat = 10;
    for (int i = 1; i <= 5; i++) begin
      dv[i] = rand_blk();
      do_req(1'b0, 1'b1, AW'(i), dv[i], rd, latv[i], ackv[i]);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (latv[i] != 1) begin n_bad++; $display("FAIL fill_lat%0d got=%0d exp=1", i, latv[i]); end
    end
    n_cmp++;
    if (txn_log.size() < 1 || ackv[5] != txn_log[0].rcyc + 2) begin
      n_bad++;
      $display("FAIL fill_stall_ack got ack_cyc=%0d exp=%0d", ackv[5], (txn_log.size() > 0) ? txn_log[0].rcyc + 2 : -1);
    end
    wait_empty(300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_empty got wb_empty=%b exp=1", wb_empty); end
    n_cmp++; if (txn_log.size() != 5) begin n_bad++; $display("FAIL fill_ntxn got=%0d exp=5", txn_log.size()); end
    for (int i = 0; i < 5 && i < txn_log.size(); i++) begin
      n_cmp++;
      if (!txn_log[i].is_wr || txn_log[i].addr !== AW'(i + 1) || txn_log[i].data !== dv[i + 1]) begin
        n_bad++;
        $display("FAIL fill_order%0d got addr=%h exp addr=%h", i, txn_log[i].addr, AW'(i + 1));
      end
    end
  endtask

  task automatic test_read_hit();
    logic [DW-1:0] d1, rd;
    int lat, ack, nrd;
    bit ok;
    do_reset();
    mem_lat = 30;
    d1 = rand_blk();
    do_req(1'b0, 1'b1, 28'h20, d1, rd, lat, ack);
    do_req(1'b1, 1'b0, 28'h20, '0, rd, lat, ack);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rhit_lat got=%0d exp=1", lat); end
    n_cmp++; if (rd !== d1) begin n_bad++; $display("FAIL rhit_data got=%h exp=%h", rd, d1); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rhit_mem_read got=%b exp=0", mem_read); end
    wait_empty(100, ok);
    nrd = 0;
    foreach (txn_log[i]) if (!txn_log[i].is_wr) nrd++;
    n_cmp++; if (!ok || nrd != 0) begin n_bad++; $display("FAIL rhit_no_memrd got reads=%0d empty=%0b exp reads=0 empty=1", nrd, ok); end
  endtask

  task automatic test_coalesce();
    logic [DW-1:0] dx, d1, d2, rd;
    int lat, ack, n30;
    bit ok;
    do_reset();
    mem_lat = 15;
    dx = rand_blk();
    d1 = rand_blk();
    d2 = rand_blk();
    do_req(1'b0, 1'b1, 28'h10, dx, rd, lat, ack);
    do_req(1'b0, 1'b1, 28'h30, d1, rd, lat, ack);
    do_req(1'b0, 1'b1, 28'h30, d2, rd, lat, ack);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL coal_lat got=%0d exp=1", lat); end
    do_req(1'b1, 1'b0, 28'h30, '0, rd, lat, ack);
    n_cmp++; if (rd !== d2) begin n_bad++; $display("FAIL coal_read got=%h exp=%h", rd, d2); end
    wait_empty(200, ok);
    n30 = 0;
    foreach (txn_log[i]) if (txn_log[i].is_wr && txn_log[i].addr == 28'h30) n30++;
    n_cmp++; if (!ok || txn_log.size() != 2 || n30 != 1) begin n_bad++; $display("FAIL coal_count got ntxn=%0d writes30=%0d exp ntxn=2 writes30=1", txn_log.size(), n30); end
    n_cmp++; if (txn_log.size() < 2 || txn_log[1].data !== d2) begin n_bad++; $display("FAIL coal_data got=%h exp=%h", (txn_log.size() > 1) ? txn_log[1].data : '0, d2); end
  endtask

  task automatic test_read_miss_during_drain();
    logic [DW-1:0] da, db, rd, exp_rd;
    int lat, ack;
    bit ok;
    do_reset();
    mem_lat = 8;
    da = rand_blk();
    db = rand_blk();
    exp_rd = model_val(28'h40);
    do_req(1'b0, 1'b1, 28'h10, da, rd, lat, ack);
    do_req(1'b0, 1'b1, 28'h50, db, rd, lat, ack);
    do_req(1'b1, 1'b0, 28'h40, '0, rd, lat, ack);
    n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rmiss_data got=%h exp=%h", rd, exp_rd); end
    n_cmp++;
    if (txn_log.size() != 2 || !txn_log[0].is_wr || txn_log[0].addr !== 28'h10 || txn_log[1].is_wr || txn_log[1].addr !== 28'h40) begin
      n_bad++;
      $display("FAIL rmiss_order got ntxn=%0d exp drain 0x10 then read 0x40", txn_log.size());
    end
    n_cmp++;
    if (txn_log.size() < 2 || ack != txn_log[1].rcyc + 1) begin
      n_bad++;
      $display("FAIL rmiss_lat got ack_cyc=%0d exp=%0d", ack, (txn_log.size() > 1) ? txn_log[1].rcyc + 1 : -1);
    end
    wait_empty(200, ok);
    n_cmp++;
    if (!ok || txn_log.size() != 3 || txn_log[2].addr !== 28'h50 || txn_log[2].data !== db) begin
      n_bad++;
      $display("FAIL rmiss_tail got ntxn=%0d empty=%0b exp third txn write 0x50", txn_log.size(), ok);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] rd;
    int lat, ack;
    bit traffic;
    do_reset();
    mem_lat = 1000;
    for (int i = 0; i < 3; i++) do_req(1'b0, 1'b1, AW'(32'h60 + i), rand_blk(), rd, lat, ack);
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre got mem_write=%b exp=1", mem_write); end
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    wmodel = mem_store;
    mem_lat = 1;
    n_cmp++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || wb_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_post got we=%b rd=%b empty=%b exp we=0 rd=0 empty=1", mem_write, mem_read, wb_empty);
    end
    traffic = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_write !== 1'b0 || mem_read !== 1'b0) traffic = 1'b1;
    end
    n_cmp++; if (traffic || txn_log.size() != 0) begin n_bad++; $display("FAIL rst_mid_quiet got traffic=%0b ntxn=%0d exp none", traffic, txn_log.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd, exp_rd;
    int lat, ack, sel;
    bit ok;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(0, 6);
      a   = AW'(32'h100 + $urandom_range(0, 7));
      d   = rand_blk();
      sel = $urandom_range(0, 15);
      if (sel < 8) begin
        // sel==0 drives read and write together: only the read may take effect.
        exp_rd = model_val(a);
        do_req(1'b1, (sel == 0), a, d, rd, lat, ack);
        n_cmp++;
        if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_read%0d addr=%h got=%h exp=%h", i, a, rd, exp_rd); end
      end else begin
        do_req(1'b0, 1'b1, a, d, rd, lat, ack);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    wait_empty(300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_empty got wb_empty=%b exp=1", wb_empty); end
    for (int k = 0; k < 8; k++) begin
      a = AW'(32'h100 + k);
      if (wmodel.exists(a)) begin
        n_cmp++;
        if (!mem_store.exists(a) || mem_store[a] !== wmodel[a]) begin
          n_bad++;
          $display("FAIL rand_memfinal addr=%h got=%h exp=%h", a, mem_store.exists(a) ? mem_store[a] : '0, wmodel[a]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_stall();
    test_read_hit();
    test_coalesce();
    test_read_miss_during_drain();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got no completion exp finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
